// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: SPI scan controller for MCP320x-family ADCs.
// Converts every channel set in a latched mask, once or continuously, in
// single-ended or differential mode, and queues {channel, result} pairs in a
// show-ahead FIFO with a sticky overflow flag.
//
// Ports:
//   clk, rst              system clock, synchronous active-low reset
//   start, stop           one-cycle scan control pulses
//   ch_mask, diff_mode,
//   continuous            scan configuration, latched on an accepted start
//   CS, P3, P5 / P4       ADC chip select, SCLK, MOSI / MISO
//   busy                  scan in progress
//   fifo_valid, fifo_ch,
//   fifo_data, fifo_rd    show-ahead result FIFO read side
//   fifo_count, overflow  FIFO occupancy and sticky drop flag
module adc_scan_ctrl #(
    parameter int unsigned CLK_DIV  = 500,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned RES_BITS = 12,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic [NUM_CH-1:0]          ch_mask,
    input  logic                       diff_mode,
    input  logic                       continuous,
    output logic                       CS,
    output logic                       P3,
    input  logic                       P4,
    output logic                       P5,
    output logic                       busy,
    output logic                       fifo_valid,
    output logic [2:0]                 fifo_ch,
    output logic [RES_BITS-1:0]        fifo_data,
    input  logic                       fifo_rd,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow
);

    localparam int unsigned FRAME_TICKS = 8 + RES_BITS;
    localparam int unsigned DIV_W       = $clog2(CLK_DIV);
    localparam int unsigned TICK_W      = $clog2(FRAME_TICKS);
    localparam int unsigned PTR_W       = $clog2(DEPTH);
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W       = 3 + RES_BITS;

    typedef enum logic [1:0] {StIdle, StFrame, StNext} state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [2:0]          ch_q, ch_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                diff_q, diff_d;
    logic                cont_q, cont_d;
    logic                stop_pend_q, stop_pend_d;
    logic [RES_BITS-1:0] shreg_q, shreg_d;
    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [ENT_W-1:0]    mem_q [DEPTH];

    logic       push, push_ok, pop, start_ok;
    logic       nxt_found;
    logic [2:0] nxt_ch;

    function automatic logic [2:0] lowest_ch(input logic [NUM_CH-1:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next set mask bit strictly above the current channel.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_q))) begin
                nxt_found = 1'b1;
                nxt_ch    = 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        tick_d      = tick_q;
        ch_d        = ch_q;
        mask_d      = mask_q;
        diff_d      = diff_q;
        cont_d      = cont_q;
        stop_pend_d = stop_pend_q;
        shreg_d     = shreg_q;
        mosi_d      = mosi_q;
        push        = 1'b0;
        start_ok    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && (ch_mask != '0)) begin
                    start_ok = 1'b1;
                    mask_d   = ch_mask;
                    diff_d   = diff_mode;
                    cont_d   = continuous;
                    ch_d     = lowest_ch(ch_mask);
                    div_d    = '0;
                    tick_d   = '0;
                    state_d  = StFrame;
                end
            end
            StFrame: begin
                if ((tick_q >= TICK_W'(8)) && (div_q == DIV_W'(CLK_DIV / 2))) begin
                    shreg_d = RES_BITS'({shreg_q, P4});
                end
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (tick_q == TICK_W'(FRAME_TICKS - 1)) begin
                        push    = 1'b1;
                        tick_d  = '0;
                        state_d = StNext;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StNext: begin
                // NEXT doubles as divider cycle 0 of tick 0, so the CS-high
                // gap between back-to-back frames is exactly CLK_DIV cycles.
                div_d  = DIV_W'(1);
                tick_d = '0;
                if (stop_pend_q) begin
                    state_d = StIdle;
                end else if (nxt_found) begin
                    ch_d    = nxt_ch;
                    state_d = StFrame;
                end else if (cont_q) begin
                    ch_d    = lowest_ch(mask_q);
                    state_d = StFrame;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if ((state_q != StIdle) && stop) stop_pend_d = 1'b1;
        if (state_d == StIdle) stop_pend_d = 1'b0;

        // Pin outputs are registered from next-state values so they line up
        // with the tick/divider counters on the same cycle.
        busy_d = (state_d != StIdle);
        cs_d   = !((state_d == StFrame) && (tick_d != '0));
        sclk_d = (state_d == StFrame) && (tick_d != '0) && (div_d >= DIV_W'(CLK_DIV / 2));
        if ((state_d == StFrame) && (div_d == '0)) begin
            case (tick_d)
                TICK_W'(1): mosi_d = 1'b1;
                TICK_W'(2): mosi_d = ~diff_d;
                TICK_W'(3): mosi_d = ch_d[2];
                TICK_W'(4): mosi_d = ch_d[1];
                TICK_W'(5): mosi_d = ch_d[0];
                TICK_W'(6), TICK_W'(7): mosi_d = 1'b0;
                default: ;
            endcase
        end

        pop      = fifo_rd && (count_q != '0);
        push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop);
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        ovf_d    = ovf_q;
        if (push && !push_ok) ovf_d = 1'b1;
        if (start_ok) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            div_q       <= '0;
            tick_q      <= '0;
            ch_q        <= '0;
            mask_q      <= '0;
            diff_q      <= 1'b0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            shreg_q     <= '0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
            ch_q        <= ch_d;
            mask_q      <= mask_d;
            diff_q      <= diff_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
            shreg_q     <= shreg_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_ok) mem_q[wr_ptr_q] <= {ch_q, shreg_q};
    end

    assign CS         = cs_q;
    assign P3         = sclk_q;
    assign P5         = mosi_q;
    assign busy       = busy_q;
    assign fifo_valid = (count_q != '0);
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    // Storage is not reset, so the head is masked while empty.
    assign {fifo_ch, fifo_data} = fifo_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: directed bench for adc_scan_ctrl with an ADC pin model and
// a scoreboard queue of expected FIFO entries checked by a read-side monitor.
module tb_adc_scan_ctrl;

    localparam int unsigned CD  = 8;
    localparam int unsigned RES = 12;
    localparam int          FRAME_CYC = 20 * CD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  ch_mask = '0;
    logic        diff_mode = 1'b0;
    logic        continuous = 1'b0;
    logic        CS, P3, P5, busy, fifo_valid, overflow;
    logic        P4 = 1'b0;
    logic [2:0]  fifo_ch;
    logic [11:0] fifo_data;
    logic        fifo_rd;
    logic [2:0]  fifo_count;
    logic        rd_auto = 1'b0;
    logic        rd_man = 1'b0;
    bit          auto_en = 1'b1;

    assign fifo_rd = rd_auto | rd_man;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] data;
    } ent_t;
    ent_t exp_q[$];
    ent_t mon_e;
    ent_t man_e;

    logic [11:0] resp [8];
    logic [11:0] bfm_cur;
    int          bump = 0;
    logic [4:0]  mosi_rx = '0;
    logic [4:0]  last_mosi = '0;
    int          rcnt = 0, fcnt = 0, frames = 0, bfm_t = 0;
    int          low_cnt = 0, hi_cnt = 0, last_low = 0, last_hi = 0;
    int          f0;

    adc_scan_ctrl #(
        .CLK_DIV (CD),
        .NUM_CH  (4),
        .RES_BITS(RES),
        .DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .ch_mask   (ch_mask),
        .diff_mode (diff_mode),
        .continuous(continuous),
        .CS        (CS),
        .P3        (P3),
        .P4        (P4),
        .P5        (P5),
        .busy      (busy),
        .fifo_valid(fifo_valid),
        .fifo_ch   (fifo_ch),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // ADC model: captures MOSI on SCLK rise, drives MISO on SCLK fall.
    always @(negedge CS) begin
        rcnt = 0;
        fcnt = 0;
        frames++;
    end

    always @(posedge P3) begin
        if (CS === 1'b0) begin
            rcnt++;
            if (rcnt <= 5) mosi_rx[5 - rcnt] = P5;
        end
    end

    always @(negedge P3) begin
        if (CS === 1'b0) begin
            fcnt++;
            bfm_t = fcnt + 1;
            if (bfm_t >= 8 && bfm_t <= 19) begin
                bfm_cur = resp[mosi_rx[2:0]];
                P4 = bfm_cur[RES + 7 - bfm_t];
            end
        end
    end

    always @(posedge CS) begin
        last_mosi = mosi_rx;
        resp[mosi_rx[2:0]] = resp[mosi_rx[2:0]] + 12'(bump);
    end

    // CS low/high run lengths in clk cycles.
    always @(posedge clk) begin
        if (CS === 1'b0) begin
            low_cnt++;
            if (hi_cnt != 0) begin
                last_hi = hi_cnt;
                hi_cnt  = 0;
            end
        end else if (CS === 1'b1) begin
            hi_cnt++;
            if (low_cnt != 0) begin
                last_low = low_cnt;
                low_cnt  = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitor: pops the head whenever reads are enabled and an entry is shown.
    always @(negedge clk) begin
        rd_auto = 1'b0;
        if (auto_en && rst && fifo_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_entry: got ch %0d data 0x%0h, want none",
                         fifo_ch, fifo_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("entry_ch", 32'(fifo_ch), 32'(mon_e.ch));
                chk("entry_data", 32'(fifo_data), 32'(mon_e.data));
            end
            rd_auto = 1'b1;
        end
    end

    task automatic pulse_start(input logic [3:0] m, input logic d, input logic c);
        ch_mask    = m;
        diff_mode  = d;
        continuous = c;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cs_rise(input string name);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < 3 * FRAME_CYC && !done; i++) begin
            @(posedge clk);
            #1;
            if (!CS) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        if (!done) timeout_fail(name);
    endtask

    task automatic wait_cs_fall(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 3 * FRAME_CYC && !done; i++) begin
            @(posedge clk);
            #1;
            if (!CS) done = 1'b1;
        end
        if (!done) timeout_fail(name);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 4 * FRAME_CYC && !done; i++) begin
            @(posedge clk);
            #1;
            if (!busy) done = 1'b1;
        end
        if (!done) timeout_fail(name);
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        auto_en = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !fifo_valid) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %0d entries outstanding, want 0", name, exp_q.size());
        end else begin
            chk({name, "_count"}, 32'(fifo_count), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) resp[i] = '0;

        // Reset state
        cycles(3);
        chk("rst_cs", 32'(CS), 32'd1);
        chk("rst_sclk", 32'(P3), 32'd0);
        chk("rst_mosi", 32'(P5), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(fifo_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ch", 32'(fifo_ch), 32'd0);
        chk("rst_data", 32'(fifo_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b1;
        cycles(2);

        // Single-shot, ch2, single-ended
        resp[2] = 12'hA5C;
        exp_q.push_back({3'd2, 12'hA5C});
        pulse_start(4'b0100, 1'b0, 1'b0);
        wait_cs_rise("t1_frame");
        chk("t1_count", 32'(fifo_count), 32'd1);
        chk("t1_busy_at_push", 32'(busy), 32'd1);
        cycles(1);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_cs_low_len", 32'(last_low), 32'(19 * CD));
        chk("t1_mosi", 32'(last_mosi), 32'b11010);
        drain("t1_drain");

        // Differential scan over ch1, ch3
        resp[1] = 12'h111;
        resp[3] = 12'h333;
        exp_q.push_back({3'd1, 12'h111});
        exp_q.push_back({3'd3, 12'h333});
        pulse_start(4'b1010, 1'b1, 1'b0);
        wait_cs_rise("t2_frame1");
        chk("t2_mosi_ch1", 32'(last_mosi), 32'b10001);
        wait_cs_rise("t2_frame2");
        chk("t2_mosi_ch3", 32'(last_mosi), 32'b10011);
        chk("t2_cs_gap", 32'(last_hi), 32'(CD));
        wait_idle("t2_idle");
        drain("t2_drain");

        // Continuous ch0 with no reads: saturate, overflow, pop on push cycle
        auto_en = 1'b0;
        bump    = 1;
        resp[0] = 12'h100;
        for (int k = 0; k < 4; k++) exp_q.push_back({3'd0, 12'(12'h100 + k)});
        pulse_start(4'b0001, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) wait_cs_rise("t3_frame");
        chk("t3_count_full", 32'(fifo_count), 32'd4);
        chk("t3_ovf_before", 32'(overflow), 32'd0);
        wait_cs_rise("t3_frame5");
        chk("t3_count_sat", 32'(fifo_count), 32'd4);
        chk("t3_ovf_set", 32'(overflow), 32'd1);
        wait_cs_fall("t3_frame6");
        repeat (19 * CD - 1) @(posedge clk);
        #1 rd_man = 1'b1;
        man_e = exp_q.pop_front();
        chk("t3_head_ch", 32'(fifo_ch), 32'(man_e.ch));
        chk("t3_head_data", 32'(fifo_data), 32'(man_e.data));
        @(posedge clk);
        #1 rd_man = 1'b0;
        chk("t3_push_edge_cs", 32'(CS), 32'd1);
        chk("t3_count_pp", 32'(fifo_count), 32'd4);
        chk("t3_ovf_pp", 32'(overflow), 32'd1);
        exp_q.push_back({3'd0, 12'h105});
        pulse_stop();
        wait_idle("t3_idle");
        bump = 0;
        chk("t3_count_end", 32'(fifo_count), 32'd4);
        drain("t3_drain");
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Ignored start with empty mask
        f0 = frames;
        pulse_start(4'b0000, 1'b0, 1'b0);
        cycles(2 * CD);
        chk("t6_mask0_busy", 32'(busy), 32'd0);
        chk("t6_mask0_ovf", 32'(overflow), 32'd1);
        chk("t6_mask0_frames", 32'(frames - f0), 32'd0);

        // Continuous ch0/ch1, stop during ch0
        resp[0] = 12'h0AA;
        resp[1] = 12'h0BB;
        exp_q.push_back({3'd0, 12'h0AA});
        pulse_start(4'b0011, 1'b0, 1'b1);
        chk("t4_ovf_cleared", 32'(overflow), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        wait_cs_fall("t4_frame");
        cycles(50);
        pulse_stop();
        wait_idle("t4_idle");
        chk("t4_cs_idle", 32'(CS), 32'd1);
        f0 = frames;
        cycles(3 * FRAME_CYC);
        chk("t4_no_more_frames", 32'(frames - f0), 32'd0);
        chk("t4_busy_end", 32'(busy), 32'd0);
        drain("t4_drain");

        // Start while busy is ignored
        resp[0] = 12'h123;
        exp_q.push_back({3'd0, 12'h123});
        f0 = frames;
        pulse_start(4'b0001, 1'b0, 1'b0);
        cycles(20);
        pulse_start(4'b1000, 1'b0, 1'b1);
        chk("t6_busy_kept", 32'(busy), 32'd1);
        wait_idle("t6_idle");
        cycles(2 * FRAME_CYC);
        chk("t6_busy_frames", 32'(frames - f0), 32'd1);
        drain("t6_drain");

        // Reset mid-frame at tick 10
        pulse_start(4'b0001, 1'b0, 1'b0);
        wait_cs_fall("t5_frame");
        repeat (9 * CD + 3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_cs", 32'(CS), 32'd1);
        chk("t5_sclk", 32'(P3), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_valid", 32'(fifo_valid), 32'd0);
        chk("t5_count", 32'(fifo_count), 32'd0);
        rst = 1'b1;
        cycles(FRAME_CYC);
        chk("t5_no_push", 32'(fifo_valid), 32'd0);
        resp[2] = 12'h5A5;
        exp_q.push_back({3'd2, 12'h5A5});
        pulse_start(4'b0100, 1'b0, 1'b0);
        wait_cs_rise("t5_restart");
        chk("t5_restart_count", 32'(fifo_count), 32'd1);
        wait_idle("t5_idle");
        drain("t5_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, want summary");
        $fatal(1, "watchdog expired");
    end

endmodule
